dmem_responder: RTL and testbench

Data-memory responder on the far end of the processor's memory-stage request interface. Accepts one load/store request per handshake (address, write data, byte/half/word length, sign), performs the access on an internal little-endian byte-addressed RAM after a configurable number of wait states, and returns a one-cycle response carrying sign- or zero-extended load data and an error flag. Sits beside the pipeline as the data-side slave; the memory stage stalls while `req_ready` is low and captures data on `rsp_valid`.

---
 rtl/dmem_responder.sv | 160 ++++++++++++++++
 tb/tb_dmem_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store per handshake, services it on an
// internal little-endian byte-addressed RAM after LATENCY wait states, returns a one-cycle response.
module dmem_responder #(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_length,
  input  logic        req_sign,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         WORDS = 2 ** (ADDR_W - 2);
  localparam logic [2:0] LAT   = 3'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [2:0]  cnt;

  logic        lat_write;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [1:0]  lat_length;
  logic        lat_sign;

  logic        accept;
  logic        enter_resp;

  logic        op_write;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [1:0]  op_length;
  logic        op_sign;
  logic        op_err;

  logic [ADDR_W-3:0] op_idx;
  logic [31:0] rd_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [3:0]  st_be;
  logic [31:0] st_lanes;

  logic [31:0] mem [WORDS];

  assign req_ready  = rst && (state != WAIT);
  assign accept     = req_valid && req_ready;
  assign enter_resp = (LAT == 3'd0) ? accept : ((state == WAIT) && (cnt == 3'd1));

  // With zero wait states the RAM edge is the accept edge, so the live request is used.
  always_comb begin
    if (LAT == 3'd0) begin
      op_write  = req_write;
      op_addr   = req_addr;
      op_wdata  = req_wdata;
      op_length = req_length;
      op_sign   = req_sign;
    end else begin
      op_write  = lat_write;
      op_addr   = lat_addr;
      op_wdata  = lat_wdata;
      op_length = lat_length;
      op_sign   = lat_sign;
    end
  end

  assign op_err = (op_length == 2'b11)
               || ((op_length == 2'b01) && op_addr[0])
               || ((op_length == 2'b10) && (op_addr[1:0] != 2'b00))
               || ((op_addr >> ADDR_W) != 32'd0);

  assign op_idx  = op_addr[ADDR_W-1:2];
  assign rd_word = mem[op_idx];

  always_comb begin
    ld_byte = rd_word[{op_addr[1:0], 3'b000} +: 8];
    ld_half = rd_word[{op_addr[1], 4'b0000} +: 16];
    case (op_length)
      2'b00:   ld_data = {{24{op_sign & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{op_sign & ld_half[15]}}, ld_half};
      default: ld_data = rd_word;
    endcase
  end

  always_comb begin
    case (op_length)
      2'b00: begin
        st_be    = 4'b0001 << op_addr[1:0];
        st_lanes = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = op_addr[1] ? 4'b1100 : 4'b0011;
        st_lanes = {2{op_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_lanes = op_wdata;
      end
    endcase
  end

  // RAM has no reset; contents survive rst.
  always_ff @(posedge clk) begin
    if (enter_resp && op_write && !op_err) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (st_be[i]) mem[op_idx][8*i +: 8] <= st_lanes[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_length <= '0;
      lat_sign   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= enter_resp;
      rsp_err   <= enter_resp && op_err;
      rsp_rdata <= (enter_resp && !op_write && !op_err) ? ld_data : '0;

      case (state)
        IDLE, RESP: begin
          if (accept) begin
            lat_write  <= req_write;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            lat_length <= req_length;
            lat_sign   <= req_sign;
            cnt        <= LAT;
            state      <= (LAT == 3'd0) ? RESP : WAIT;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 0, 3) driven by a vector table,
// hand-written timing sequences and random traffic checked against a byte-array model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic        req_write  [3];
  logic [31:0] req_addr   [3];
  logic [31:0] req_wdata  [3];
  logic [1:0]  req_length [3];
  logic        req_sign   [3];
  logic        rsp_valid  [3];
  logic [31:0] rsp_rdata  [3];
  logic        rsp_err    [3];

  int checks = 0;
  int errors = 0;

  logic [7:0] mm [3][4096];

  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 3;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dmem_responder #(.ADDR_W(12), .LATENCY(lat_of(g))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_length(req_length[g]),
      .req_sign  (req_sign[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_err(input logic [31:0] a, input logic [1:0] len);
    longint nb;
    if (len == 2'b11) return 1'b1;
    nb = longint'(1) << len;
    return ((longint'(a) % nb) != 0) || (longint'(a) >= 4096);
  endfunction

  function automatic logic [31:0] m_load(input int k, input logic [31:0] a,
                                         input logic [1:0] len, input bit s);
    int nb;
    longint v;
    nb = 1 << len;
    v  = 0;
    for (int i = 0; i < nb; i++) v += longint'(mm[k][int'(a) + i]) << (8 * i);
    if (s && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) v -= (longint'(1) << (8 * nb));
    return 32'(v);
  endfunction

  task automatic m_store(input int k, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] len);
    int nb;
    nb = 1 << len;
    for (int i = 0; i < nb; i++) mm[k][int'(a) + i] = 8'(d >> (8 * i));
  endtask

  task automatic do_req(input int k, input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] len, input bit s,
                        output logic [31:0] rd, output logic er);
    int n;
    @(negedge clk);
    req_write[k] = w; req_addr[k] = a; req_wdata[k] = d;
    req_length[k] = len; req_sign[k] = s; req_valid[k] = 1'b1;
    n = 0;
    while (!req_ready[k] && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("ready_timeout", 32'(n), 32'd0);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid[k] && n < 20);
    chk($sformatf("latency_k%0d", k), 32'(n), 32'(1 + lat_of(k)));
    rd = rsp_rdata[k];
    er = rsp_err[k];
  endtask

  task automatic apply(input string name, input int k, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [1:0] len, input bit s,
                       input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic        er;
    do_req(k, w, a, d, len, s, rd, er);
    chk({name, "_rdata"}, rd, exp_rd);
    chk({name, "_err"}, 32'(er), 32'(exp_er));
    if (w && !m_err(a, len)) m_store(k, a, d, len);
  endtask

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  len;
    bit          s;
    logic [31:0] exp_rd;
    logic        exp_er;
  } vec_t;

  vec_t vt [15];

  initial begin
    logic [31:0] a, d, er_rd;
    logic [1:0]  len;
    bit          w, s, ee;
    int          r;

    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_write[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0;   req_length[k] = '0;  req_sign[k] = 1'b0;
    end

    vt[0]  = '{1, 32'h10,   32'hDEADBEEF, 2'b10, 0, 32'h0,        0};
    vt[1]  = '{0, 32'h10,   32'h0,        2'b10, 0, 32'hDEADBEEF, 0};
    vt[2]  = '{0, 32'h11,   32'h0,        2'b00, 1, 32'hFFFFFFBE, 0};
    vt[3]  = '{0, 32'h11,   32'h0,        2'b00, 0, 32'h000000BE, 0};
    vt[4]  = '{0, 32'h12,   32'h0,        2'b01, 1, 32'hFFFFDEAD, 0};
    vt[5]  = '{1, 32'h13,   32'h7F,       2'b00, 0, 32'h0,        0};
    vt[6]  = '{0, 32'h10,   32'h0,        2'b10, 0, 32'h7FADBEEF, 0};
    vt[7]  = '{0, 32'h11,   32'h0,        2'b01, 0, 32'h0,        1};
    vt[8]  = '{1, 32'h12,   32'h11111111, 2'b10, 0, 32'h0,        1};
    vt[9]  = '{1, 32'h10,   32'h22222222, 2'b11, 0, 32'h0,        1};
    vt[10] = '{1, 32'h1000, 32'h33333333, 2'b10, 0, 32'h0,        1};
    vt[11] = '{0, 32'h10,   32'h0,        2'b10, 0, 32'h7FADBEEF, 0};
    vt[12] = '{0, 32'h10,   32'h0,        2'b01, 0, 32'h0000BEEF, 0};
    vt[13] = '{0, 32'h10,   32'h0,        2'b01, 1, 32'hFFFFBEEF, 0};
    vt[14] = '{0, 32'h13,   32'h0,        2'b00, 1, 32'h0000007F, 0};

    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_ready", 32'(req_ready[k]), 32'd0);
      chk("reset_valid", 32'(rsp_valid[k]), 32'd0);
      chk("reset_rdata", rsp_rdata[k], 32'd0);
      chk("reset_err", 32'(rsp_err[k]), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);

    foreach (vt[i])
      apply($sformatf("vec%0d", i), 0, vt[i].w, vt[i].a, vt[i].d, vt[i].len, vt[i].s,
            vt[i].exp_rd, vt[i].exp_er);

    // LATENCY=0 back-to-back store then load.
    @(negedge clk);
    req_write[1] = 1; req_addr[1] = 32'h20; req_wdata[1] = 32'h12345678;
    req_length[1] = 2'b10; req_sign[1] = 0; req_valid[1] = 1;
    @(negedge clk);
    chk("b2b_st_valid", 32'(rsp_valid[1]), 32'd1);
    chk("b2b_st_err", 32'(rsp_err[1]), 32'd0);
    chk("b2b_st_ready", 32'(req_ready[1]), 32'd1);
    req_write[1] = 0;
    @(negedge clk);
    chk("b2b_ld_valid", 32'(rsp_valid[1]), 32'd1);
    chk("b2b_ld_rdata", rsp_rdata[1], 32'h12345678);
    chk("b2b_ld_ready", 32'(req_ready[1]), 32'd1);
    req_valid[1] = 0;
    @(negedge clk);
    chk("b2b_idle_valid", 32'(rsp_valid[1]), 32'd0);
    chk("b2b_idle_rdata", rsp_rdata[1], 32'd0);
    m_store(1, 32'h20, 32'h12345678, 2'b10);

    // LATENCY=3: held request, fields change in WAIT, next accept in RESP reads new data.
    @(negedge clk);
    req_write[2] = 1; req_addr[2] = 32'h40; req_wdata[2] = 32'hCAFEF00D;
    req_length[2] = 2'b10; req_sign[2] = 0; req_valid[2] = 1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_write[2] = 0; req_wdata[2] = 32'h0BADBAD0;
      end
      chk($sformatf("l3_ready_c%0d", c), 32'(req_ready[2]), 32'(c == 4));
      chk($sformatf("l3_valid_c%0d", c), 32'(rsp_valid[2]), 32'(c == 4));
    end
    chk("l3_st_err", 32'(rsp_err[2]), 32'd0);
    chk("l3_st_rdata", rsp_rdata[2], 32'd0);
    @(posedge clk); #1;
    req_valid[2] = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("l3_ld_valid_c%0d", c), 32'(rsp_valid[2]), 32'(c == 4));
    end
    chk("l3_raw_rdata", rsp_rdata[2], 32'hCAFEF00D);
    @(negedge clk);
    chk("l3_after_valid", 32'(rsp_valid[2]), 32'd0);
    chk("l3_after_rdata", rsp_rdata[2], 32'd0);
    m_store(2, 32'h40, 32'hCAFEF00D, 2'b10);

    // Reset during WAIT drops a pending store.
    apply("pre_rst_st", 2, 1, 32'h30, 32'h55555555, 2'b10, 0, 32'h0, 0);
    @(negedge clk);
    req_write[2] = 1; req_addr[2] = 32'h30; req_wdata[2] = 32'hAAAAAAAA;
    req_length[2] = 2'b10; req_valid[2] = 1;
    @(posedge clk); #1;
    req_valid[2] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("mid_rst_ready", 32'(req_ready[2]), 32'd0);
      chk("mid_rst_valid", 32'(rsp_valid[2]), 32'd0);
      chk("mid_rst_rdata", rsp_rdata[2], 32'd0);
      chk("mid_rst_err", 32'(rsp_err[2]), 32'd0);
      @(negedge clk);
    end
    rst = 1'b1;
    apply("post_rst_ld", 2, 0, 32'h30, 32'h0, 2'b10, 0, 32'h55555555, 0);

    // Random traffic against the byte-array model.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 64; i++)
        apply("init", k, 1, 32'(4 * i), $urandom, 2'b10, 0, 32'h0, 0);
      for (int i = 0; i < 150; i++) begin
        r = $urandom_range(0, 9);
        if (r == 0)      a = 32'h1000 + 32'($urandom_range(0, 255));
        else if (r == 1) a = $urandom | 32'h0001_0000;
        else             a = 32'($urandom_range(0, 255));
        w   = 1'($urandom_range(0, 1));
        len = 2'($urandom_range(0, 3));
        s   = 1'($urandom_range(0, 1));
        d   = $urandom;
        ee  = m_err(a, len);
        er_rd = (w || ee) ? 32'h0 : m_load(k, a, len, s);
        apply($sformatf("rand_k%0d", k), k, w, a, d, len, s, er_rd, ee);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
